// File: rtl/rsz_arb_pkg.sv
// Shared definitions for the round-robin driver-net schedulers: state
// encoding, grant index width helper and the default hold limit.
package rsz_arb_pkg;

    // Default number of consecutive grant cycles before a waiting requester may preempt
    localparam int MAX_HOLD_DEFAULT = 8;

    // Hold counter width, large enough for the largest legal MAX_HOLD (255)
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Grant index width; a single requester still needs one bit to hold an index
    function automatic int id_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/load_group_rr_arbiter_if.sv
// Request/grant bundle between the load-group requesters and the
// driver-net arbiter. The requester side is the master.
interface load_group_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = rsz_arb_pkg::id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] release_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic               gnt_valid_o;
    logic [ID_W-1:0]    gnt_id_o;
    logic               busy_o;

    modport master (
        output req_i,
        output release_i,
        input  gnt_o,
        input  gnt_valid_o,
        input  gnt_id_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  release_i,
        output gnt_o,
        output gnt_valid_o,
        output gnt_id_o,
        output busy_o
    );
endinterface

// File: rtl/rr_pick_first.sv
// Rotating-priority encoder: returns the first set request bit found when
// scanning upward from ptr with wrap-around, as one-hot and as an index.
module rr_pick_first
    import rsz_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = rsz_arb_pkg::id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    int              cand_s;
    logic [ID_W-1:0] cand_idx_s;

    // Scan NUM_REQ positions starting at ptr; the first requesting position wins
    always_comb begin
        onehot     = '0;
        idx        = '0;
        found      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s     = (int'(ptr) + i) % NUM_REQ;
            cand_idx_s = ID_W'(cand_s);
            if (!found && req[cand_idx_s]) begin
                found              = 1'b1;
                idx                = cand_idx_s;
                onehot[cand_idx_s] = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/load_group_rr_arbiter.sv
// Round-robin owner selection for one shared buffered driver net. Exactly
// one registered one-hot grant steers the driver-select mux, and a dead
// TURN cycle separates consecutive owners so two drivers never overlap.
module load_group_rr_arbiter
    import rsz_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_group_rr_arbiter_if.slave  bus
);

    localparam int                ID_W      = id_width(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_e         state_r;
    logic [ID_W-1:0]    owner_r;
    logic [ID_W-1:0]    ptr_r;
    logic [HOLD_W-1:0]  hold_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic               gnt_valid_r;
    logic [ID_W-1:0]    gnt_id_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic               pick_found_s;

    logic               owner_rel_s;
    logic               owner_req_s;
    logic               others_s;
    logic               exit_s;
    logic [ID_W-1:0]    ptr_next_s;

    rr_pick_first #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (bus.req_i),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .found  (pick_found_s)
    );

    // Ownership ends on the owner's release, the owner dropping its request, or
    // preemption once the hold limit is reached while someone else is waiting.
    // The saturated counter still satisfies the limit, so a late arrival preempts.
    always_comb begin
        owner_rel_s = bus.release_i[owner_r];
        owner_req_s = bus.req_i[owner_r];
        others_s    = |(bus.req_i & ~gnt_r);
        if (state_r == ST_GRANT) begin
            exit_s = owner_rel_s | ~owner_req_s | ((hold_r >= HOLD_LAST) & others_s);
        end else begin
            exit_s = 1'b0;
        end
    end

    // Priority moves to the requester just above the outgoing owner, with wrap
    always_comb begin
        if (owner_r == LAST_ID) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = owner_r + ID_W'(1);
        end
    end

    // Grant FSM with registered outputs; reset drops the grant at once, no turnaround
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= '0;
            ptr_r       <= '0;
            hold_r      <= '0;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r     <= ST_GRANT;
                        owner_r     <= pick_idx_s;
                        hold_r      <= '0;
                        gnt_r       <= pick_onehot_s;
                        gnt_valid_r <= 1'b1;
                        gnt_id_r    <= pick_idx_s;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        gnt_id_r    <= '0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (hold_r < HOLD_MAX) begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end else begin
                        hold_r <= hold_r;
                    end
                    if (exit_s) begin
                        state_r     <= ST_TURN;
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        gnt_id_r    <= '0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                ST_TURN: begin
                    state_r     <= ST_IDLE;
                    ptr_r       <= ptr_next_s;
                    hold_r      <= '0;
                    gnt_r       <= '0;
                    gnt_valid_r <= 1'b0;
                    gnt_id_r    <= '0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hold_r      <= '0;
                    gnt_r       <= '0;
                    gnt_valid_r <= 1'b0;
                    gnt_id_r    <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_o       = gnt_r;
    assign bus.gnt_valid_o = gnt_valid_r;
    assign bus.gnt_id_o    = gnt_id_r;
    assign bus.busy_o      = busy_r;

endmodule

// File: tb/tb_load_group_rr_arbiter.sv
// Directed bench for load_group_rr_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Stimulus pushes the expected grant episodes (owner, length, gap before it)
// into a queue; a monitor pops one per grant start and checks it cycle by cycle.
module tb_load_group_rr_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        int         len;   // grant cycles, -1 = not checked
        int         gap;   // dead cycles before this grant, -1 = not checked
    } exp_t;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    exp_t exp_q[$];

    load_group_rr_arbiter_if #(.NUM_REQ(4)) tb_if ();

    load_group_rr_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id, input int len, input int gap);
        exp_t e;
        e.gnt = g;
        e.id  = id;
        e.len = len;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: sample on the falling edge, away from the active edge
    exp_t cur;
    bit   have_cur;
    bit   in_grant;
    int   len_cnt;
    int   gap_cnt;

    initial begin
        have_cur = 1'b0;
        in_grant = 1'b0;
        len_cnt  = 0;
        gap_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_grant = 1'b0;
                have_cur = 1'b0;
                gap_cnt  = 0;
            end else if (tb_if.gnt_valid_o) begin
                if (!in_grant) begin
                    if (exp_q.size() == 0) begin
                        have_cur = 1'b0;
                        check("unexpected_grant", int'(tb_if.gnt_o), 0);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        if (cur.gap >= 0) check("gap_cycles", gap_cnt, cur.gap);
                    end
                    in_grant = 1'b1;
                    len_cnt  = 0;
                end
                len_cnt++;
                if (have_cur) begin
                    check("gnt_o", int'(tb_if.gnt_o), int'(cur.gnt));
                    check("gnt_id_o", int'(tb_if.gnt_id_o), int'(cur.id));
                end
                check("busy_in_grant", int'(tb_if.busy_o), 1);
            end else begin
                if (in_grant) begin
                    if (have_cur && cur.len >= 0) check("grant_len", len_cnt, cur.len);
                    check("busy_in_turn", int'(tb_if.busy_o), 1);
                    in_grant = 1'b0;
                    gap_cnt  = 0;
                end
                gap_cnt++;
                check("gnt_o_idle", int'(tb_if.gnt_o), 0);
                check("gnt_id_o_idle", int'(tb_if.gnt_id_o), 0);
            end
        end
    end

    // Assert reset at #1 after an edge, hold two edges, release at #1 after an edge
    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        tb_if.req_i     = 4'b1111;
        tb_if.release_i = 4'b0000;

        // Reset with every requester asking: no grant while reset is held
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt_o", int'(tb_if.gnt_o), 0);
        check("rst_gnt_valid_o", int'(tb_if.gnt_valid_o), 0);
        check("rst_gnt_id_o", int'(tb_if.gnt_id_o), 0);
        check("rst_busy_o", int'(tb_if.busy_o), 0);

        // First edge after reset grants requester 0; it releases in its 3rd cycle
        push(4'b0001, 2'd0, 3, -1);
        rst_n = 1'b1;
        @(posedge clk); #1 tb_if.req_i = 4'b0001;
        @(posedge clk); #1;
        @(posedge clk); #1 tb_if.release_i = 4'b0001;
        @(posedge clk); #1;
        tb_if.release_i = 4'b0000;
        tb_if.req_i     = 4'b0000;
        repeat (5) @(posedge clk);

        // All four requesting: 8-cycle grants in rotation with 2 dead cycles between
        do_reset();
        push(4'b0001, 2'd0, 8, -1);
        push(4'b0010, 2'd1, 8, 2);
        push(4'b0100, 2'd2, 8, 2);
        push(4'b1000, 2'd3, 8, 2);
        push(4'b0001, 2'd0, 1, 2);
        rst_n = 1'b1;
        tb_if.req_i = 4'b1111;
        repeat (41) @(posedge clk);
        #1 tb_if.req_i = 4'b0000;
        repeat (4) @(posedge clk);

        // Lone requester 2 holds 20 cycles, then requester 1 preempts via the saturated count
        push(4'b0100, 2'd2, 20, -1);
        push(4'b0010, 2'd1, 1, 2);
        push(4'b0100, 2'd2, 5, 2);
        push(4'b1000, 2'd3, -1, 2);
        #1 tb_if.req_i = 4'b0100;
        repeat (20) @(posedge clk);
        #1 tb_if.req_i = 4'b0110;
        repeat (3) @(posedge clk);
        #1 tb_if.req_i = 4'b0100;

        // Owner 2 ignores non-owner release bits, then releases with requester 3 waiting
        repeat (3) @(posedge clk);
        #1 tb_if.release_i = 4'b1011;
        repeat (4) @(posedge clk);
        #1;
        tb_if.release_i = 4'b0100;
        tb_if.req_i     = 4'b1100;
        repeat (3) @(posedge clk);
        #1;
        tb_if.release_i = 4'b0000;
        tb_if.req_i     = 4'b1010;

        // Reset mid-grant of owner 3: grant drops without a clock, pointer back to 0
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_gnt_o", int'(tb_if.gnt_o), 0);
        check("async_rst_gnt_valid_o", int'(tb_if.gnt_valid_o), 0);
        check("async_rst_gnt_id_o", int'(tb_if.gnt_id_o), 0);
        check("async_rst_busy_o", int'(tb_if.busy_o), 0);
        push(4'b0010, 2'd1, 1, -1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 tb_if.req_i = 4'b0000;
        repeat (5) @(posedge clk);
        #1;

        check("expected_grants_left", exp_q.size(), 0);
        check("grant_still_open", int'(in_grant), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
